// File: rtl/shift_unit.sv
// Serial shifter: one bit per cycle over shamt cycles, IDLE/SHIFT/DONE.
// Define SHIFT_ROTATE_EN to enable ROL/ROR; otherwise they act as pass.
module shift_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] shamt_in,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
`ifdef SHIFT_ROTATE_EN
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;
`endif

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  count_q, count_d;
  logic        shift_op;
  logic [31:0] step;
  logic        unused_shamt;

  assign unused_shamt = ^shamt_in[31:5];
  assign data_out     = data_q;

  always_comb begin
    shift_op = 1'b0;
    unique case (op)
      OP_SLL, OP_SRL, OP_SRA: shift_op = 1'b1;
`ifdef SHIFT_ROTATE_EN
      OP_ROL, OP_ROR:         shift_op = 1'b1;
`endif
      default:                shift_op = 1'b0;
    endcase
  end

  // single-bit step of the working register
  always_comb begin
    step = data_q;
    unique case (op_q)
      OP_SLL:  step = {data_q[30:0], 1'b0};
      OP_SRL:  step = {1'b0, data_q[31:1]};
      OP_SRA:  step = {data_q[31], data_q[31:1]};
`ifdef SHIFT_ROTATE_EN
      OP_ROL:  step = {data_q[30:0], data_q[31]};
      OP_ROR:  step = {data_q[0], data_q[31:1]};
`endif
      default: step = data_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    count_d = count_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = data_in;
          op_d    = op;
          count_d = shamt_in[4:0];
          if (shift_op && (shamt_in[4:0] != 5'd0)) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        busy    = 1'b1;
        data_d  = step;
        count_d = count_q - 5'd1;
        if (count_q == 5'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= 32'h0;
      op_q    <= 3'b000;
      count_q <= 5'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit: arithmetic reference model checked every cycle,
// plus directed runs with literal results and done latencies.
module tb_shift_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] shamt_in;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  int n_pass  = 0;
  int n_total = 0;
  int ecnt    = 0;

  shift_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .shamt_in (shamt_in),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // result of applying op k times, computed directly from the op meaning
  function automatic logic [31:0] f(input logic [2:0] o,
                                    input logic [31:0] d, input int k);
    logic signed [31:0] s;
    s = d;
    case (o)
      3'b001:  return d << k;
      3'b010:  return d >> k;
      3'b011:  return s >>> k;
      3'b100:  return (k == 0) ? d : ((d << k) | (d >> (32 - k)));
      3'b101:  return (k == 0) ? d : ((d >> k) | (d << (32 - k)));
      default: return d;
    endcase
  endfunction

  function automatic int steps(input logic [2:0] o, input logic [31:0] sh);
    bit is_sh;
    is_sh = (o == 3'b001) || (o == 3'b010) || (o == 3'b011);
`ifdef SHIFT_ROTATE_EN
    is_sh = is_sh || (o == 3'b100) || (o == 3'b101);
`endif
    return is_sh ? int'(sh[4:0]) : 0;
  endfunction

  logic        m_act = 1'b0;
  int          m_el  = 0;
  int          m_S   = 0;
  logic [2:0]  m_op  = 3'b000;
  logic [31:0] m_d0  = 32'h0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_act <= 1'b0;
      m_el  <= 0;
      m_S   <= 0;
      m_op  <= 3'b000;
      m_d0  <= 32'h0;
    end else if (m_act) begin
      if (m_el + 1 > m_S) m_act <= 1'b0;
      else m_el <= m_el + 1;
    end else if (start) begin
      m_act <= 1'b1;
      m_el  <= 0;
      m_S   <= steps(op, shamt_in);
      m_op  <= op;
      m_d0  <= data_in;
    end
  end

  always @(negedge clk) begin
    chk("cyc busy", 32'(busy), 32'(m_act));
    chk("cyc done", 32'(done), 32'(m_act && (m_el == m_S)));
    chk("cyc data", data_out, f(m_op, m_d0, m_act ? m_el : m_S));
  end

  // xe: edges from start-raise edge (edge 0) until done is seen
  task automatic run(input string nm, input logic [2:0] o,
                     input logic [31:0] d, input logic [31:0] sh,
                     input logic [31:0] xd, input int xe, input int rs);
    int base;
    bit got;
    @(negedge clk);
    #1;
    base     = ecnt;
    op       = o;
    data_in  = d;
    shamt_in = sh;
    start    = 1'b1;
    got      = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (rs != 0 && ecnt - base == rs - 1) begin
        start   = 1'b1;
        data_in = 32'hFFFF_FFFF;
      end else begin
        start = 1'b0;
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk({nm, " edges"}, got ? 32'(ecnt - base) : 32'hFFFF_FFFF, 32'(xe));
    chk({nm, " data"}, data_out, xd);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b1;
    op       = 3'b001;
    data_in  = 32'hDEAD_BEEF;
    shamt_in = 32'd3;
    #1;
    chk("rst data", data_out, 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst done", 32'(done), 32'h0);
    repeat (3) @(negedge clk);
    chk("rst start ignored", 32'(busy), 32'h0);
    #1;
    reset = 1'b1;
    start = 1'b0;

    run("sll4", 3'b001, 32'h1, 32'd4, 32'h10, 5, 0);
    run("sra31", 3'b011, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32, 0);
    run("srl31", 3'b010, 32'h8000_0000, 32'd31, 32'h1, 32, 0);
    run("srl16", 3'b010, 32'h8000_0000, 32'h10, 32'h8000, 17, 0);
    run("srl32", 3'b010, 32'h8000_0000, 32'h20, 32'h8000_0000, 1, 0);
    run("sra2", 3'b011, 32'h4000_0000, 32'd2, 32'h1000_0000, 3, 0);
    run("pass", 3'b000, 32'h1234, 32'd5, 32'h1234, 1, 0);
    run("rsvd", 3'b110, 32'hCAFE, 32'd3, 32'hCAFE, 1, 0);
    run("sll0", 3'b001, 32'h55, 32'd0, 32'h55, 1, 0);
`ifdef SHIFT_ROTATE_EN
    run("ror1", 3'b101, 32'h1, 32'd1, 32'h8000_0000, 2, 0);
    run("rol4", 3'b100, 32'h8000_0001, 32'd4, 32'h18, 5, 0);
`else
    run("ror1", 3'b101, 32'h1, 32'd1, 32'h1, 1, 0);
    run("rol4", 3'b100, 32'h8000_0001, 32'd4, 32'h8000_0001, 1, 0);
`endif
    run("sll8 restart", 3'b001, 32'h1, 32'd8, 32'h100, 9, 3);

    repeat (5) @(negedge clk);
    chk("idle hold", data_out, 32'h100);

    @(negedge clk);
    #1;
    op       = 3'b001;
    data_in  = 32'h1;
    shamt_in = 32'd8;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort data", data_out, 32'h0);
    chk("abort busy", 32'(busy), 32'h0);
    chk("abort done", 32'(done), 32'h0);
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort no done", 32'(done), 32'h0);
    #1;
    start = 1'b0;
    reset = 1'b1;

    run("after abort", 3'b001, 32'h3, 32'd2, 32'hC, 3, 0);

    repeat (3) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 SHALL have port clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low reset; clears all state when 0.
REQ-003 SHALL have port start  in  1  one-cycle request to begin a shift; sampled only in IDLE.
REQ-004 SHALL have port op  in  3  operation: 000 pass, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR, 110/111 reserved.
REQ-005 SHALL have port shamt_in  in  32  shift-amount word from the upstream shift-amount select; only bits [4:0] used.
REQ-006 SHALL have port data_in  in  32  operand to be shifted; captured on accepted start.
REQ-007 SHALL have port data_out  out  32  working/result register.
REQ-008 SHALL have port busy  out  1  high from cycle after accepted start until done cycle inclusive.
REQ-009 SHALL have port done  out  1  one-cycle pulse; data_out is final while done=1 and held after.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-011 IDLE + start=1 SHALL capture data_in into data_out, op into op_q, shamt_in[4:0] into 5-bit count_q.
REQ-012 On capture, SHALL go to DONE if count is 0 or op is pass/reserved; otherwise go to SHIFT.
REQ-013 SHIFT SHALL per cycle: shift data_out by exactly one bit per op_q, decrement count_q; on count_q==1 go to DONE.
REQ-014 Per-bit rules SHALL be: SLL fill 0 at bit 0; SRL fill 0 at bit 31; SRA replicate bit 31; ROL bit31->bit0; ROR bit0->bit31.
REQ-015 DONE SHALL assert done for one cycle, then go to IDLE unconditionally.
REQ-016 Latency SHALL be: start sampled at edge 0 -> done high after edge N+1, N = shamt_in[4:0] (N=0 -> after edge 1).
REQ-017 start while busy (SHIFT or DONE) SHALL be ignored; no re-capture, no effect on count_q.
REQ-018 shamt_in[31:5] SHALL be ignored (shamt_in=0x20 behaves as N=0).
REQ-019 data_out SHALL hold its value in IDLE until the next accepted start.
REQ-020 busy SHALL be low in IDLE, high in SHIFT and DONE.

Reset
REQ-021 reset=0 SHALL immediately (no clock) force state IDLE, data_out=0x00000000, count_q=0, op_q=000, busy=0, done=0.
REQ-022 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; first start after release is accepted normally.
REQ-023 start SHALL be ignored on the first rising edge at which reset is 0.

Configuration
REQ-024 Macro SHIFT_ROTATE_EN defined: ROL/ROR SHALL operate per REQ-014.
REQ-025 Macro SHIFT_ROTATE_EN undefined: op 100/101 SHALL be treated as reserved (pass, done after 1 cycle, data_out=data_in); rotate logic absent.

Verification
REQ-026 SLL, data_in=0x00000001, shamt_in=4 -> done after edge 5, data_out=0x00000010, busy high edges 1-5.
REQ-027 SRA, data_in=0x80000000, shamt_in=31 -> done after edge 32, data_out=0xFFFFFFFF; SRL same -> 0x00000001.
REQ-028 SRL, data_in=0x80000000, shamt_in=0x00000010 -> done after edge 17, data_out=0x00008000; shamt_in=0x00000020 -> done after edge 1, data_out=0x80000000.
REQ-029 SLL shamt 8 started, start pulsed again at edge 3 with data_in=0xFFFFFFFF -> ignored, result 0x00000100 for data_in=0x00000001; reset=0 at edge 4 of a second run -> outputs zero immediately, no done.
REQ-030 ROR, data_in=0x00000001, shamt_in=1 -> with SHIFT_ROTATE_EN data_out=0x80000000 after edge 2; without -> data_out=0x00000001 after edge 1.
